// File: rtl/mem_access_if.sv
// MEM-stage request/response and MIO bus signals of the load/store engine.
interface mem_access_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned NBE = XLEN / 8;

  // pipeline side
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [2:0]      req_dmtype;
  logic            flush;
  logic            stall;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  // MIO bus side
  logic            CPU_MIO;
  logic            mem_w;
  logic [XLEN-1:0] Addr_out;
  logic [XLEN-1:0] Data_out;
  logic [NBE-1:0]  mem_be;
  logic [2:0]      DMType;
  logic [XLEN-1:0] Data_in;
  logic            MIO_ready;

  // the load/store engine
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_dmtype, flush, Data_in, MIO_ready,
    output req_ready, stall, rsp_valid, rsp_rdata, rsp_err,
           CPU_MIO, mem_w, Addr_out, Data_out, mem_be, DMType
  );

  // the pipeline plus the memory that drive it
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_dmtype, flush, Data_in, MIO_ready,
    input  req_ready, stall, rsp_valid, rsp_rdata, rsp_err,
           CPU_MIO, mem_w, Addr_out, Data_out, mem_be, DMType
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: MIO handshake with wait states, bus timeout,
// misalignment trap, byte/half/word lane steering and load extension.
module mem_access_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  mem_access_if.slave bus
);

  localparam int unsigned NBE = XLEN / 8;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // latched request
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      dmtype_q, dmtype_d;

  // access bookkeeping
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             squash_q, squash_d;

  // response registers
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

  // bus registers
  logic            cpu_mio_q, cpu_mio_d;
  logic            mem_w_q, mem_w_d;
  logic [XLEN-1:0] addr_out_q, addr_out_d;
  logic [XLEN-1:0] data_out_q, data_out_d;
  logic [NBE-1:0]  mem_be_q, mem_be_d;

  // combinational helpers
  logic             accept_c;
  logic             misaligned_c;
  logic [XLEN-1:0]  wdata_steer_c;
  logic [NBE-1:0]   be_steer_c;
  logic [XLEN-1:0]  rdata_ext_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             timeout_c;

  // request accepted only from IDLE and only when not being squashed
  assign accept_c  = (state_q == IDLE) && bus.req_valid && !bus.flush;
  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign timeout_c = (cnt_inc_c == CNT_W'(TIMEOUT_CYC));

  // alignment check on the incoming request
  always_comb begin
    misaligned_c = 1'b0;
    case (bus.req_dmtype)
      DM_H, DM_HU: misaligned_c = bus.req_addr[0];
      DM_B, DM_BU: misaligned_c = 1'b0;
      default:     misaligned_c = |bus.req_addr[1:0];
    endcase
  end

  // store data replication and byte enables for the incoming request
  always_comb begin
    wdata_steer_c = '0;
    be_steer_c    = '1;
    if (bus.req_we) begin
      case (bus.req_dmtype)
        DM_B, DM_BU: begin
          wdata_steer_c = {(XLEN/8){bus.req_wdata[7:0]}};
          be_steer_c    = NBE'(1) << bus.req_addr[1:0];
        end
        DM_H, DM_HU: begin
          wdata_steer_c = {(XLEN/16){bus.req_wdata[15:0]}};
          be_steer_c    = NBE'(3) << {bus.req_addr[1], 1'b0};
        end
        default: begin
          wdata_steer_c = bus.req_wdata;
          be_steer_c    = '1;
        end
      endcase
    end
  end

  // lane select and sign/zero extension of the returned read data
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b      = bus.Data_in[{addr_q[1:0], 3'b000} +: 8];
    lane_h      = bus.Data_in[{addr_q[1], 4'b0000} +: 16];
    rdata_ext_c = bus.Data_in;
    case (dmtype_q)
      DM_H:    rdata_ext_c = {{(XLEN-16){lane_h[15]}}, lane_h};
      DM_HU:   rdata_ext_c = {{(XLEN-16){1'b0}}, lane_h};
      DM_B:    rdata_ext_c = {{(XLEN-8){lane_b[7]}}, lane_b};
      DM_BU:   rdata_ext_c = {{(XLEN-8){1'b0}}, lane_b};
      default: rdata_ext_c = bus.Data_in;
    endcase
  end

  // next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dmtype_d    = dmtype_q;
    cnt_d       = cnt_q;
    squash_d    = squash_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    cpu_mio_d   = cpu_mio_q;
    mem_w_d     = mem_w_q;
    addr_out_d  = addr_out_q;
    data_out_d  = data_out_q;
    mem_be_d    = mem_be_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          we_d        = bus.req_we;
          addr_d      = bus.req_addr;
          dmtype_d    = bus.req_dmtype;
          cnt_d       = '0;
          squash_d    = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          if (misaligned_c) begin
            // trap without touching the bus
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = ACCESS;
            cpu_mio_d  = 1'b1;
            mem_w_d    = bus.req_we;
            addr_out_d = {bus.req_addr[XLEN-1:2], 2'b00};
            data_out_d = wdata_steer_c;
            mem_be_d   = be_steer_c;
          end
        end
      end

      ACCESS: begin
        // a flush lets the bus cycle finish but hides the response
        if (bus.flush) begin
          squash_d = 1'b1;
        end
        if (bus.MIO_ready || timeout_c) begin
          state_d     = RESP;
          rsp_valid_d = !(squash_q || bus.flush);
          cnt_d       = '0;
          cpu_mio_d   = 1'b0;
          mem_w_d     = 1'b0;
          addr_out_d  = '0;
          data_out_d  = '0;
          mem_be_d    = '0;
          if (bus.MIO_ready) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = we_q ? '0 : rdata_ext_c;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      RESP: begin
        state_d     = IDLE;
        squash_d    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dmtype_q    <= '0;
      cnt_q       <= '0;
      squash_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cpu_mio_q   <= 1'b0;
      mem_w_q     <= 1'b0;
      addr_out_q  <= '0;
      data_out_q  <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dmtype_q    <= dmtype_d;
      cnt_q       <= cnt_d;
      squash_q    <= squash_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cpu_mio_q   <= cpu_mio_d;
      mem_w_q     <= mem_w_d;
      addr_out_q  <= addr_out_d;
      data_out_q  <= data_out_d;
      mem_be_q    <= mem_be_d;
    end
  end

  // a flush arriving during RESP still cancels the response pulse
  assign bus.rsp_valid = rsp_valid_q && !bus.flush;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.stall     = accept_c || (state_q == ACCESS);
  assign bus.CPU_MIO   = cpu_mio_q;
  assign bus.mem_w     = mem_w_q;
  assign bus.Addr_out  = addr_out_q;
  assign bus.Data_out  = data_out_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.DMType    = dmtype_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, corner sequences,
// and randomized transactions against a behavioural reference model.
module tb_mem_access_unit;

  localparam int TO = 15;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dt;
    int          wait_n;    // wait states before MIO_ready; -1 = never
    int          flush_at;  // ACCESS cycle (1-based) with flush high; 0 = none
    logic [31:0] din;
    int          nacc;      // expected number of ACCESS cycles
    logic        err;
    logic [31:0] rdata;
    logic [31:0] dout;
    logic [3:0]  be;
  } vec_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  mem_access_if #(.XLEN(32)) bif ();

  mem_access_unit #(.XLEN(32), .TIMEOUT_CYC(15), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // behavioural reference: sizes, alignment and extension from plain arithmetic
  function automatic vec_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] dt, input int wait_n, input logic [31:0] din);
    vec_t        e;
    int unsigned sz;
    int unsigned lo;
    logic [31:0] mask;
    logic [31:0] v;
    logic        ok_timing;
    logic        misal;
    e.we       = we;
    e.addr     = addr;
    e.wdata    = wdata;
    e.dt       = dt;
    e.wait_n   = wait_n;
    e.flush_at = 0;
    e.din      = din;
    sz         = (dt == 3'd0) ? 4 : ((dt == 3'd1 || dt == 3'd2) ? 2 : 1);
    lo         = 32'(addr[1:0]);
    misal      = (lo % sz) != 0;
    ok_timing  = (wait_n >= 0) && (wait_n < TO);
    e.nacc     = misal ? 0 : (ok_timing ? wait_n + 1 : TO);
    e.err      = misal || !ok_timing;
    mask       = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    e.be       = we ? 4'(((32'd1 << sz) - 32'd1) << lo) : 4'hF;
    if (!we)
      e.dout = 32'h0;
    else if (sz == 4)
      e.dout = wdata;
    else
      e.dout = (wdata & mask) * ((sz == 2) ? 32'h0001_0001 : 32'h0101_0101);
    v = (din >> (8 * lo)) & mask;
    if ((dt == 3'd1 || dt == 3'd3) && v[8 * sz - 1])
      v = v | ~mask;
    e.rdata = (we || e.err) ? 32'h0 : v;
    return e;
  endfunction

  // drive one request through accept, ACCESS cycles, RESP and back to IDLE
  task automatic run_txn(input string tag, input vec_t v);
    int          stall_cnt;
    logic [31:0] aexp;
    stall_cnt      = 0;
    aexp           = v.addr & 32'hFFFF_FFFC;
    bif.req_valid  = 1'b1;
    bif.req_we     = v.we;
    bif.req_addr   = v.addr;
    bif.req_wdata  = v.wdata;
    bif.req_dmtype = v.dt;
    bif.flush      = 1'b0;
    bif.MIO_ready  = 1'b0;
    bif.Data_in    = $urandom;
    #1;
    chk({tag, " req_ready at accept"}, 32'(bif.req_ready), 32'd1);
    if (bif.stall) stall_cnt++;
    step();
    for (int k = 1; k <= v.nacc; k++) begin
      bif.MIO_ready = (k == v.wait_n + 1);
      bif.Data_in   = bif.MIO_ready ? v.din : $urandom;
      bif.flush     = (k == v.flush_at);
      #1;
      chk({tag, " CPU_MIO in access"}, 32'(bif.CPU_MIO), 32'd1);
      chk({tag, " mem_w"}, 32'(bif.mem_w), 32'(v.we));
      chk({tag, " Addr_out"}, bif.Addr_out, aexp);
      chk({tag, " mem_be"}, 32'(bif.mem_be), 32'(v.be));
      chk({tag, " DMType"}, 32'(bif.DMType), 32'(v.dt));
      chk({tag, " req_ready in access"}, 32'(bif.req_ready), 32'd0);
      if (v.we) chk({tag, " Data_out"}, bif.Data_out, v.dout);
      if (bif.stall) stall_cnt++;
      step();
    end
    bif.MIO_ready = 1'b0;
    bif.flush     = 1'b0;
    #1;
    chk({tag, " rsp_valid"}, 32'(bif.rsp_valid), (v.flush_at == 0) ? 32'd1 : 32'd0);
    chk({tag, " CPU_MIO in resp"}, 32'(bif.CPU_MIO), 32'd0);
    chk({tag, " req_ready in resp"}, 32'(bif.req_ready), 32'd0);
    if (v.flush_at == 0) begin
      chk({tag, " rsp_err"}, 32'(bif.rsp_err), 32'(v.err));
      chk({tag, " rsp_rdata"}, bif.rsp_rdata, v.rdata);
    end
    if (bif.stall) stall_cnt++;
    step();
    bif.req_valid = 1'b0;
    #1;
    chk({tag, " req_ready after resp"}, 32'(bif.req_ready), 32'd1);
    chk({tag, " rsp_valid after resp"}, 32'(bif.rsp_valid), 32'd0);
    chk({tag, " stall cycles"}, 32'(stall_cnt), 32'(v.nacc + 1));
  endtask

  vec_t tbl[15];

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bif.req_valid  = 1'b0;
    bif.req_we     = 1'b0;
    bif.req_addr   = '0;
    bif.req_wdata  = '0;
    bif.req_dmtype = '0;
    bif.flush      = 1'b0;
    bif.Data_in    = '0;
    bif.MIO_ready  = 1'b0;

    //            we    addr          wdata         dt    wait flush din           nacc err   rdata         dout          be
    tbl[0]  = '{1'b0, 32'h0000_1003, 32'h0,        3'd3, 0,  0, 32'h80FF_FF00, 1,  1'b0, 32'hFFFF_FF80, 32'h0,        4'hF};
    tbl[1]  = '{1'b1, 32'h0000_2002, 32'h1234_ABCD, 3'd1, 3,  0, 32'h0,        4,  1'b0, 32'h0,        32'hABCD_ABCD, 4'hC};
    tbl[2]  = '{1'b0, 32'h0000_3001, 32'h0,        3'd0, 0,  0, 32'h0,        0,  1'b1, 32'h0,        32'h0,        4'hF};
    tbl[3]  = '{1'b0, 32'h0000_4000, 32'h0,        3'd0, -1, 0, 32'h0,        15, 1'b1, 32'h0,        32'h0,        4'hF};
    tbl[4]  = '{1'b0, 32'h0000_5001, 32'h0,        3'd4, 1,  0, 32'h1234_8756, 2,  1'b0, 32'h0000_0087, 32'h0,        4'hF};
    tbl[5]  = '{1'b0, 32'h0000_6002, 32'h0,        3'd1, 0,  0, 32'h8001_7FFF, 1,  1'b0, 32'hFFFF_8001, 32'h0,        4'hF};
    tbl[6]  = '{1'b0, 32'h0000_6002, 32'h0,        3'd2, 2,  0, 32'h8001_7FFF, 3,  1'b0, 32'h0000_8001, 32'h0,        4'hF};
    tbl[7]  = '{1'b0, 32'h0000_7000, 32'h0,        3'd1, 0,  0, 32'h1234_F00D, 1,  1'b0, 32'hFFFF_F00D, 32'h0,        4'hF};
    tbl[8]  = '{1'b1, 32'h0000_8002, 32'hDEAD_BE5A, 3'd3, 1,  0, 32'h0,        2,  1'b0, 32'h0,        32'h5A5A_5A5A, 4'h4};
    tbl[9]  = '{1'b1, 32'h0000_9000, 32'hCAFE_F00D, 3'd0, 2,  0, 32'h0,        3,  1'b0, 32'h0,        32'hCAFE_F00D, 4'hF};
    tbl[10] = '{1'b1, 32'h0000_A001, 32'h5555_5555, 3'd1, 0,  0, 32'h0,        0,  1'b1, 32'h0,        32'h0,        4'h3};
    tbl[11] = '{1'b0, 32'h0000_B004, 32'h0,        3'd0, 14, 0, 32'h1122_3344, 15, 1'b0, 32'h1122_3344, 32'h0,        4'hF};
    tbl[12] = '{1'b0, 32'h0000_B000, 32'h0,        3'd0, 2,  2, 32'h0BAD_F00D, 3,  1'b0, 32'h0BAD_F00D, 32'h0,        4'hF};
    tbl[13] = '{1'b1, 32'h0000_C003, 32'h0000_0077, 3'd4, 0,  0, 32'h0,        1,  1'b0, 32'h0,        32'h7777_7777, 4'h8};
    tbl[14] = '{1'b0, 32'h0000_D008, 32'h0,        3'd0, 15, 0, 32'hFFFF_FFFF, 15, 1'b1, 32'h0,        32'h0,        4'hF};

    repeat (2) step();
    // reset values
    chk("reset rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(bif.rsp_err), 32'd0);
    chk("reset rsp_rdata", bif.rsp_rdata, 32'd0);
    chk("reset CPU_MIO", 32'(bif.CPU_MIO), 32'd0);
    chk("reset mem_w", 32'(bif.mem_w), 32'd0);
    chk("reset Addr_out", bif.Addr_out, 32'd0);
    chk("reset Data_out", bif.Data_out, 32'd0);
    chk("reset mem_be", 32'(bif.mem_be), 32'd0);
    chk("reset DMType", 32'(bif.DMType), 32'd0);
    chk("reset req_ready", 32'(bif.req_ready), 32'd1);
    chk("reset stall", 32'(bif.stall), 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 15; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i]);
    end

    // flush with a request in IDLE: not accepted, no stall
    bif.req_valid  = 1'b1;
    bif.req_we     = 1'b0;
    bif.req_addr   = 32'h0000_0100;
    bif.req_dmtype = 3'd0;
    bif.flush      = 1'b1;
    #1;
    chk("idle flush stall", 32'(bif.stall), 32'd0);
    step();
    chk("idle flush not accepted CPU_MIO", 32'(bif.CPU_MIO), 32'd0);
    chk("idle flush not accepted req_ready", 32'(bif.req_ready), 32'd1);
    bif.req_valid = 1'b0;
    bif.flush     = 1'b0;
    step();

    // flush during RESP hides the response pulse
    bif.req_valid  = 1'b1;
    bif.req_addr   = 32'h0000_3002;
    bif.req_dmtype = 3'd0;
    step();
    bif.flush = 1'b1;
    #1;
    chk("resp flush rsp_valid", 32'(bif.rsp_valid), 32'd0);
    step();
    bif.flush     = 1'b0;
    bif.req_valid = 1'b0;
    #1;
    chk("resp flush back to idle", 32'(bif.req_ready), 32'd1);
    step();

    // reset in the middle of ACCESS, then a back-to-back load
    bif.req_valid  = 1'b1;
    bif.req_we     = 1'b1;
    bif.req_addr   = 32'h0000_E000;
    bif.req_wdata  = 32'h1357_9BDF;
    bif.req_dmtype = 3'd0;
    step();
    chk("pre-reset CPU_MIO", 32'(bif.CPU_MIO), 32'd1);
    chk("pre-reset mem_w", 32'(bif.mem_w), 32'd1);
    reset         = 1'b1;
    bif.req_valid = 1'b0;
    step();
    chk("mid reset CPU_MIO", 32'(bif.CPU_MIO), 32'd0);
    chk("mid reset mem_w", 32'(bif.mem_w), 32'd0);
    chk("mid reset Addr_out", bif.Addr_out, 32'd0);
    chk("mid reset Data_out", bif.Data_out, 32'd0);
    chk("mid reset mem_be", 32'(bif.mem_be), 32'd0);
    chk("mid reset rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("mid reset req_ready", 32'(bif.req_ready), 32'd1);
    reset = 1'b0;
    run_txn("post-reset load", model(1'b0, 32'h0000_F002, 32'h0, 3'd3, 0, 32'hAB7F_0000));

    // randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      vec_t        r;
      logic        we;
      logic [2:0]  dt;
      int          w;
      we = 1'($urandom_range(0, 1));
      dt = 3'($urandom_range(0, 4));
      w  = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 5));
      r  = model(we, $urandom, $urandom, dt, w, $urandom);
      if (r.nacc > 0 && $urandom_range(0, 5) == 0)
        r.flush_at = int'($urandom_range(1, 32'(r.nacc)));
      run_txn($sformatf("rnd%0d", i), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
